// File: rtl/tipi_rpi_master.sv
// tipi_rpi_master: Pi-side initiator of the TIPI serial latch link.
// Optional feature macro: TIPI_RPI_PARITY_EN (write/read parity checks).

module tipi_rpi_master #(
  parameter int HALF_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_dc,
  input  logic [0:7] cmd_data,
  output logic       rsp_valid,
  output logic [0:7] rsp_data,
  output logic       rsp_perr,
  output logic       rsp_abort,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_dc,
  output logic       r_dout,
  input  logic       r_din,
  input  logic       r_reset
);

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] PH_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [3:0] WR_LAST = 4'd8;
`ifdef TIPI_RPI_PARITY_EN
  localparam logic [3:0] RD_LAST = 4'd9;
`else
  localparam logic [3:0] RD_LAST = 4'd8;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [3:0]    nbit;
  logic [3:0]    last_bit;
  logic          wr_q, wr_d;
  logic [0:7]    data_q, data_d;
  logic [0:7]    rx_q, rx_d;
  logic          phase_end;
  logic          rs1_q, rst_s;

  logic          clk_d, le_d, rt_d, dc_d, dout_d;
  logic          vld_d, abort_d;
  logic [0:7]    rdat_d;

`ifdef TIPI_RPI_PARITY_EN
  logic perr_q, perr_d;
  logic rperr_q, rperr_d;
  assign rsp_perr = rperr_q;
`else
  assign rsp_perr = 1'b0;
`endif

  assign phase_end = (cnt_q == PH_LAST);
  assign nbit      = bit_q + 4'd1;
  assign last_bit  = wr_q ? WR_LAST : RD_LAST;
  assign cmd_ready = (state_q == IDLE) && !rst_s && !reset;

  // r_reset comes from the TI clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q <= 1'b0;
      rst_s <= 1'b0;
    end else begin
      rs1_q <= r_reset;
      rst_s <= rs1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    wr_d    = wr_q;
    data_d  = data_q;
    rx_d    = rx_q;
    clk_d   = r_clk;
    le_d    = r_le;
    rt_d    = r_rt;
    dc_d    = r_dc;
    dout_d  = r_dout;
    vld_d   = 1'b0;
    rdat_d  = rsp_data;
    abort_d = rsp_abort;
`ifdef TIPI_RPI_PARITY_EN
    perr_d  = perr_q;
    rperr_d = rperr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = LOW;
          cnt_d   = '0;
          bit_d   = 4'd0;
          wr_d    = cmd_write;
          data_d  = cmd_data;
          rx_d    = '0;
          clk_d   = 1'b0;
          le_d    = !cmd_write;
          rt_d    = !cmd_write;
          dc_d    = cmd_dc;
          dout_d  = cmd_write && cmd_data[0];
`ifdef TIPI_RPI_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      LOW: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = HIGH;
          cnt_d   = '0;
          clk_d   = 1'b1;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          if (!wr_q && bit_q != 4'd0 && bit_q <= 4'd8)
            rx_d = {rx_q[1:7], r_din};
`ifdef TIPI_RPI_PARITY_EN
          if (wr_q && bit_q == 4'd7)
            perr_d = r_din ^ (^data_q);
          if (!wr_q && bit_q == 4'd9)
            perr_d = r_din ^ (^rx_q);
`endif
          cnt_d = '0;
          clk_d = 1'b0;
          if (bit_q == last_bit) begin
            state_d = IDLE;
            le_d    = 1'b0;
            vld_d   = 1'b1;
            abort_d = 1'b0;
            rdat_d  = wr_q ? 8'h00 : rx_d;
`ifdef TIPI_RPI_PARITY_EN
            rperr_d = perr_d;
`endif
          end else begin
            state_d = LOW;
            bit_d   = nbit;
            le_d    = wr_q && (nbit == 4'd8);
            dout_d  = wr_q && (nbit < 4'd8)
                      && data_q[nbit[2:0]];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // link reset from the TI side wins over everything
    if (rst_s && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      clk_d   = 1'b0;
      le_d    = 1'b0;
      vld_d   = 1'b1;
      abort_d = 1'b1;
      rdat_d  = 8'h00;
`ifdef TIPI_RPI_PARITY_EN
      rperr_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      rx_q      <= '0;
      r_clk     <= 1'b0;
      r_le      <= 1'b0;
      r_rt      <= 1'b0;
      r_dc      <= 1'b0;
      r_dout    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_abort <= 1'b0;
`ifdef TIPI_RPI_PARITY_EN
      perr_q    <= 1'b0;
      rperr_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      r_clk     <= clk_d;
      r_le      <= le_d;
      r_rt      <= rt_d;
      r_dc      <= dc_d;
      r_dout    <= dout_d;
      rsp_valid <= vld_d;
      rsp_data  <= rdat_d;
      rsp_abort <= abort_d;
`ifdef TIPI_RPI_PARITY_EN
      perr_q    <= perr_d;
      rperr_q   <= rperr_d;
`endif
    end
  end

endmodule

// File: tb/tb_tipi_rpi_master.sv
// tb_tipi_rpi_master: TIPI master against a TI-side latch model.
// Build with TIPI_RPI_PARITY_EN to exercise the parity variant.

module tb_tipi_rpi_master;

  localparam int HP  = 8;
  localparam int NWR = 9;
`ifdef TIPI_RPI_PARITY_EN
  localparam int NRD = 10;
  localparam bit PAR = 1'b1;
`else
  localparam int NRD = 9;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic       cmd_dc = 1'b0;
  logic [0:7] cmd_data = '0;
  logic       r_reset = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_perr, rsp_abort;
  logic [0:7] rsp_data;
  logic       r_clk, r_le, r_rt, r_dc, r_dout, r_din;

  int checks = 0;
  int errors = 0;

  // TI-side latch model
  logic [7:0] rc_m = '0, rd_m = '0;
  logic [7:0] tc_m = '0, td_m = '0;
  logic [7:0] wsr = '0;
  logic [8:0] osr = '0;
  logic       first = 1'b0;
  logic       mdl_din;
  int         rise_cnt = 0;
  int         base = 0;
  int         fault_at = -1;

  always #5 clk = ~clk;

  tipi_rpi_master #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_dc(cmd_dc),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_perr(rsp_perr), .rsp_abort(rsp_abort),
    .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt),
    .r_dc(r_dc), .r_dout(r_dout),
    .r_din(r_din), .r_reset(r_reset)
  );

  always @(posedge r_clk) begin
    rise_cnt <= rise_cnt + 1;
    if (r_le && !r_rt) begin
      if (r_dc) rd_m <= wsr;
      else      rc_m <= wsr;
    end else if (!r_le && !r_rt) begin
      wsr <= {wsr[6:0], r_dout};
    end else if (r_le && r_rt) begin
      osr   <= r_dc ? {td_m, ^td_m} : {tc_m, ^tc_m};
      first <= 1'b1;
    end else if (first) begin
      first <= 1'b0;
    end else begin
      osr <= {osr[7:0], 1'b0};
    end
  end

  assign mdl_din = r_rt ? osr[8] : ^wsr;
  assign r_din = mdl_din ^ ((fault_at >= 0) &&
                 (rise_cnt - base == fault_at + 1));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic dc,
                       input logic [7:0] d, input int flt,
                       output int waited);
    waited = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_dc = dc;
    cmd_data = d;
    while (!cmd_ready && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 2000) chk("accept_timeout", 0, 1);
    @(posedge clk);
    base = rise_cnt;
    fault_at = flt;
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_dc = ~dc;
    cmd_data = ~d;
  endtask

  task automatic wait_rsp(output int lat,
                          output logic [7:0] d,
                          output logic pe, output logic ab);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 3000);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    d = rsp_data;
    pe = rsp_perr;
    ab = rsp_abort;
    fault_at = -1;
  endtask

  typedef struct {
    logic       w;
    logic       dc;
    logic [7:0] d;
    logic [7:0] ti;
    int         flt;
    logic [7:0] xd;
    logic       xpe;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic       w, dc, pe, ab, xpe, acc;
    logic [7:0] d, xd, rd;
    logic [7:0] exp_rc, exp_rd;
    int         flt, lat, wt, n, nv;

    tv[0] = '{1'b1, 1'b1, 8'hA5, 8'h00, -1, 8'h00, 1'b0};
    tv[1] = '{1'b0, 1'b1, 8'h00, 8'hAB, -1, 8'hAB, 1'b0};
    tv[2] = '{1'b1, 1'b0, 8'h3C, 8'h00, -1, 8'h00, 1'b0};
    tv[3] = '{1'b0, 1'b0, 8'h00, 8'h00, -1, 8'h00, 1'b0};
    tv[4] = '{1'b1, 1'b1, 8'h01, 8'h00, 7, 8'h00, PAR};
    tv[5] = '{1'b0, 1'b1, 8'h00, 8'hF0, 9, 8'hF0, PAR};
    tv[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, -1, 8'h00, 1'b0};
    tv[7] = '{1'b0, 1'b0, 8'h00, 8'h5C, -1, 8'h5C, 1'b0};
    exp_rc = 8'h00;
    exp_rd = 8'h00;

    #1;
    chk("reset_outputs",
        {cmd_ready, rsp_valid, rsp_data, rsp_perr, rsp_abort,
         r_clk, r_le, r_rt, r_dc, r_dout}, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      if (!tv[i].w) begin
        if (tv[i].dc) td_m = tv[i].ti;
        else          tc_m = tv[i].ti;
      end
      issue(tv[i].w, tv[i].dc, tv[i].d, tv[i].flt, wt);
      wait_rsp(lat, rd, pe, ab);
      chk($sformatf("v%0d_data", i), rd, tv[i].xd);
      chk($sformatf("v%0d_perr", i), pe, tv[i].xpe);
      chk($sformatf("v%0d_abort", i), ab, 0);
      chk($sformatf("v%0d_lat", i), lat,
          2 * HP * (tv[i].w ? NWR : NRD));
      chk($sformatf("v%0d_idle_link", i),
          {r_clk, r_le, r_rt, r_dc},
          {2'b00, !tv[i].w, tv[i].dc});
      if (tv[i].w) begin
        if (tv[i].dc) exp_rd = tv[i].d;
        else          exp_rc = tv[i].d;
      end
      chk($sformatf("v%0d_rc", i), rc_m, exp_rc);
      chk($sformatf("v%0d_rd", i), rd_m, exp_rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), rsp_valid, 0);
    end

    // control pair, second command in the rsp_valid clk
    tc_m = 8'h00;
    issue(1'b1, 1'b0, 8'h3C, -1, wt);
    wait_rsp(lat, rd, pe, ab);
    exp_rc = 8'h3C;
    chk("b2b_ready", cmd_ready, 1);
    issue(1'b0, 1'b0, 8'h00, -1, wt);
    chk("b2b_no_wait", wt, 0);
    wait_rsp(lat, rd, pe, ab);
    chk("b2b_rc", rc_m, 8'h3C);
    chk("b2b_tc_data", rd, 8'h00);
    chk("b2b_lat", lat, 2 * HP * NRD);

    // randomized traffic against the latch model
    for (int i = 0; i < 24; i++) begin
      w  = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      flt = ($urandom_range(0, 3) == 0) ? (w ? 7 : 9) : -1;
      if (!w) begin
        if (dc) td_m = 8'($urandom);
        else    tc_m = 8'($urandom);
      end
      xd  = w ? 8'h00 : (dc ? td_m : tc_m);
      xpe = PAR && (flt >= 0);
      issue(w, dc, d, flt, wt);
      wait_rsp(lat, rd, pe, ab);
      if (w) begin
        if (dc) exp_rd = d;
        else    exp_rc = d;
      end
      chk($sformatf("r%0d_data", i), rd, xd);
      chk($sformatf("r%0d_perr", i), pe, xpe);
      chk($sformatf("r%0d_lat", i), lat,
          2 * HP * (w ? NWR : NRD));
      chk($sformatf("r%0d_latches", i),
          {rc_m, rd_m}, {exp_rc, exp_rd});
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    // link reset during a read
    td_m = 8'h96;
    issue(1'b0, 1'b1, 8'h00, -1, wt);
    n = 0;
    while (rise_cnt - base < 5 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ab_reached_bit4", r_clk, 1);
    #2 r_reset = 1'b1;
    n = 0;
    nv = 0;
    ab = 1'b0;
    rd = 8'hFF;
    pe = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (!r_clk && n == 0) n = k;
      if (rsp_valid) begin
        nv++;
        ab = rsp_abort;
        rd = rsp_data;
        pe = rsp_perr;
      end
    end
    chk("ab_clk_low_by_3", (n >= 1) && (n <= 3), 1);
    chk("ab_one_rsp", nv, 1);
    chk("ab_abort", ab, 1);
    chk("ab_data", rd, 0);
    chk("ab_perr", pe, 0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_dc = 1'b0;
    cmd_data = 8'h11;
    acc = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      acc = acc | cmd_ready | r_clk | rsp_valid;
    end
    chk("ab_blocked", acc, 0);
    cmd_valid = 1'b0;
    #2 r_reset = 1'b0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ab_ready_delay", n, 2);

    // async reset in the middle of a write
    issue(1'b1, 1'b0, 8'hFF, -1, wt);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("ar_pre_high", {r_clk, r_dout}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("ar_outputs",
        {cmd_ready, rsp_valid, rsp_data, rsp_perr, rsp_abort,
         r_clk, r_le, r_rt, r_dc, r_dout}, 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    nv = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (rsp_valid) nv++;
    end
    chk("ar_no_rsp", nv, 0);
    chk("ar_rc_kept", rc_m, exp_rc);
    issue(1'b1, 1'b1, 8'h5A, -1, wt);
    wait_rsp(lat, rd, pe, ab);
    chk("ar_next_rd", rd_m, 8'h5A);
    chk("ar_next_rsp", {rd, pe, ab}, 0);
    chk("ar_next_lat", lat, 2 * HP * NWR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
